// File: rtl/lcd_byte_arbiter.sv
// lcd_byte_arbiter
//   Shares one LCD nibble-transfer engine between two byte-level requesters.
//   A granted byte is sent as two nibble transfers, high nibble first. Each
//   transfer carries its own post-nibble delay. The owner receives a
//   one-cycle done pulse after the low nibble completes.
//
// Ports
//   CLK, RST                  clock; synchronous active-high reset
//   reqN_valid/rs/data        byte request from requester N (hold until ready)
//   reqN_ready                combinational accept strobe (IDLE only)
//   reqN_done                 one-cycle pulse: requester N byte fully sent
//   busy                      high whenever a byte is in flight
//   grant_id                  owner of the current/last byte
//   xfer_cmd, xfer_delay      {RS, nibble} and post-nibble delay in clocks
//   xfer_send / xfer_done     handshake with the nibble-transfer engine
module lcd_byte_arbiter #(
    parameter int FREQ    = 50000000,
    parameter int DELAY_W = 21
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               req0_valid,
    input  logic               req0_rs,
    input  logic [7:0]         req0_data,
    output logic               req0_ready,
    output logic               req0_done,
    input  logic               req1_valid,
    input  logic               req1_rs,
    input  logic [7:0]         req1_data,
    output logic               req1_ready,
    output logic               req1_done,
    output logic               busy,
    output logic               grant_id,
    output logic [4:0]         xfer_cmd,
    output logic [DELAY_W-1:0] xfer_delay,
    output logic               xfer_send,
    input  logic               xfer_done
);

    localparam longint unsigned T1US = longint'(FREQ) / 64'd1000000;

    localparam logic [DELAY_W-1:0] DLY_HI  = DELAY_W'(T1US * 64'd10);
    localparam logic [DELAY_W-1:0] DLY_LO  = DELAY_W'(T1US * 64'd53);
    localparam logic [DELAY_W-1:0] DLY_CLR = DELAY_W'(T1US * 64'd3000);

    // The longest delay (clear/home) must fit in xfer_delay.
    if (T1US * 64'd3000 >= (64'd1 << DELAY_W)) begin : g_delay_w_too_small
        $error("lcd_byte_arbiter: DELAY_W too small for T1US*3000");
    end

    typedef enum logic [2:0] {
        IDLE,
        LOAD_HI,
        SEND_HI,
        LOAD_LO,
        SEND_LO
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       last_grant;
    logic       grant_ok;
    logic       grant_sel;
    logic       rs_q;
    logic [7:0] data_q;

    // Clear display (0x01) and return home (0x02/0x03) commands need the
    // long settle time; every other low nibble uses the standard delay.
    function automatic logic [DELAY_W-1:0] lo_delay(input logic rs,
                                                    input logic [7:0] data);
        if (!rs && (data == 8'h01 || data == 8'h02 || data == 8'h03))
            return DLY_CLR;
        return DLY_LO;
    endfunction

    always_comb begin
        state_next = state;
        grant_ok   = 1'b0;
        grant_sel  = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    // Contest: the requester that did not win last time wins.
                    grant_ok  = 1'b1;
                    grant_sel = ~last_grant;
                end else if (req0_valid) begin
                    grant_ok  = 1'b1;
                    grant_sel = 1'b0;
                end else if (req1_valid) begin
                    grant_ok  = 1'b1;
                    grant_sel = 1'b1;
                end
                if (grant_ok)
                    state_next = LOAD_HI;
            end
            LOAD_HI: state_next = SEND_HI;
            SEND_HI: if (xfer_done) state_next = LOAD_LO;
            LOAD_LO: state_next = SEND_LO;
            SEND_LO: if (xfer_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A grant during reset would be discarded, so ready is held low then.
    assign req0_ready = grant_ok && !grant_sel && !RST;
    assign req1_ready = grant_ok &&  grant_sel && !RST;
    assign busy       = (state != IDLE);
    assign xfer_send  = (state == SEND_HI) || (state == SEND_LO);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            xfer_cmd   <= '0;
            xfer_delay <= '0;
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
        end else begin
            state     <= state_next;
            req0_done <= 1'b0;
            req1_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_ok) begin
                        last_grant <= grant_sel;
                        grant_id   <= grant_sel;
                    end
                end
                LOAD_HI: begin
                    xfer_cmd   <= {rs_q, data_q[7:4]};
                    xfer_delay <= DLY_HI;
                end
                LOAD_LO: begin
                    xfer_cmd   <= {rs_q, data_q[3:0]};
                    xfer_delay <= lo_delay(rs_q, data_q);
                end
                SEND_LO: begin
                    if (xfer_done) begin
                        req0_done <= ~grant_id;
                        req1_done <=  grant_id;
                    end
                end
                default: ;
            endcase
        end
    end

    // Byte capture happens only in the accept cycle; the requester may
    // change its data freely at any other time.
    always_ff @(posedge CLK) begin
        if (state == IDLE && grant_ok) begin
            rs_q   <= grant_sel ? req1_rs   : req0_rs;
            data_q <= grant_sel ? req1_data : req0_data;
        end
    end

endmodule
